// File: rtl/holy_core_pkg.sv
// Shared types for the AXI transaction scheduler.
// Holds the FSM states, owner encoding and arbitration helper.
package holy_core_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWNER_I = 1'b0,
    OWNER_D = 1'b1
  } arb_owner_t;

  // On conflict the side not served last wins.
  function automatic arb_owner_t rr_pick(
    input logic       i_req,
    input logic       d_req,
    input arb_owner_t last
  );
    if (i_req && d_req)
      return (last == OWNER_I) ? OWNER_D : OWNER_I;
    else if (d_req)
      return OWNER_D;
    else
      return OWNER_I;
  endfunction

endpackage

// File: rtl/txn_watchdog.sv
// Saturating no-progress counter for a held grant.
// Expires after TIMEOUT_CYCLES quiet cycles.
module txn_watchdog #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic clear,
  output logic expire
);

  localparam int CW =
    (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] MAX = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt <= '0;
    else if (!run || clear)
      cnt <= '0;
    else if (cnt != MAX)
      cnt <= cnt + CW'(1);
  end

  assign expire = run && !clear && (cnt == MAX);

endmodule

// File: rtl/axi_txn_scheduler.sv
// Arbitrates the shared AXI master between I and D caches.
// Tracks one transaction at a time through ADDR and DATA.
module axi_txn_scheduler
  import holy_core_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_req,
  input  logic i_write,
  input  logic d_req,
  input  logic d_write,
  input  logic ar_hs,
  input  logic r_last_hs,
  input  logic aw_hs,
  input  logic w_last_hs,
  input  logic b_hs,
  output logic grant_i,
  output logic grant_d,
  output logic owner,
  output logic bus_busy,
  output logic timeout_err
);

  arb_state_t state, state_n;
  arb_owner_t own, own_n;
  arb_owner_t last, last_n;
  logic wr, wr_n;
  logic w_done, w_done_n;
  logic b_done, b_done_n;
  logic err, err_n;
  logic own_req, w_seen, b_seen;
  logic any_hs, expire;

  assign any_hs = ar_hs | r_last_hs | aw_hs
                | w_last_hs | b_hs;
  assign own_req = (own == OWNER_D) ? d_req : i_req;
  assign w_seen = w_done | w_last_hs;
  assign b_seen = b_done | b_hs;

  txn_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wdog (
    .clk   (clk),
    .rst_n (rst_n),
    .run   (state != IDLE),
    .clear (any_hs),
    .expire(expire)
  );

  always_comb begin
    state_n  = state;
    own_n    = own;
    last_n   = last;
    wr_n     = wr;
    w_done_n = w_done;
    b_done_n = b_done;
    err_n    = err;
    case (state)
      IDLE: begin
        w_done_n = 1'b0;
        b_done_n = 1'b0;
        if (i_req || d_req) begin
          own_n   = rr_pick(i_req, d_req, last);
          last_n  = own_n;
          wr_n    = (own_n == OWNER_D) ? d_write : i_write;
          state_n = ADDR;
        end
      end
      ADDR: begin
        if (wr) begin
          w_done_n = w_seen;
          b_done_n = b_seen;
        end
        if (wr ? aw_hs : ar_hs)
          state_n = DATA;
        else if (!own_req)
          state_n = IDLE;
      end
      DATA: begin
        if (wr) begin
          w_done_n = w_seen;
          b_done_n = b_seen;
          if (w_seen && b_seen)
            state_n = IDLE;
        end else if (r_last_hs) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
    if (expire) begin
      state_n = IDLE;
      err_n   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      own     <= OWNER_I;
      last    <= OWNER_I;
      wr      <= 1'b0;
      w_done  <= 1'b0;
      b_done  <= 1'b0;
      err     <= 1'b0;
      grant_i <= 1'b0;
      grant_d <= 1'b0;
    end else begin
      state   <= state_n;
      own     <= own_n;
      last    <= last_n;
      wr      <= wr_n;
      w_done  <= w_done_n;
      b_done  <= b_done_n;
      err     <= err_n;
      grant_i <= (state_n != IDLE) && (own_n == OWNER_I);
      grant_d <= (state_n != IDLE) && (own_n == OWNER_D);
    end
  end

  assign owner       = own;
  assign bus_busy    = (state != IDLE);
  assign timeout_err = err;

endmodule

// File: tb/tb_axi_txn_scheduler.sv
// Directed bench for axi_txn_scheduler with a cycle model.
// Model tracks ownership and progress per transaction.
module tb_axi_txn_scheduler;

  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic i_req = 0, i_write = 0, d_req = 0, d_write = 0;
  logic ar_hs = 0, r_last_hs = 0, aw_hs = 0;
  logic w_last_hs = 0, b_hs = 0;
  logic grant_i, grant_d, owner, bus_busy, timeout_err;

  int checks = 0;
  int failures = 0;
  int held;

  always #5 clk = ~clk;

  axi_txn_scheduler #(.TIMEOUT_CYCLES(TO)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_req      (i_req),
    .i_write    (i_write),
    .d_req      (d_req),
    .d_write    (d_write),
    .ar_hs      (ar_hs),
    .r_last_hs  (r_last_hs),
    .aw_hs      (aw_hs),
    .w_last_hs  (w_last_hs),
    .b_hs       (b_hs),
    .grant_i    (grant_i),
    .grant_d    (grant_d),
    .owner      (owner),
    .bus_busy   (bus_busy),
    .timeout_err(timeout_err)
  );

  task automatic chk(input string nm, input int got,
                     input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d t=%0t",
               nm, got, exp, $time);
    end
  endtask

  // model: who holds the bus and how far the transaction got
  logic m_hold, m_who, m_wr, m_adone, m_wf, m_bf;
  logic m_err, m_prio;
  int   m_quiet;

  always @(posedge clk or negedge rst_n) begin : model
    logic hold, who, wr, ad, wf, bf, err, prio, hs, req;
    int q;
    if (!rst_n) begin
      m_hold <= 0; m_who <= 0; m_wr <= 0; m_adone <= 0;
      m_wf <= 0; m_bf <= 0; m_err <= 0;
      m_prio <= 1; m_quiet <= 0;
    end else begin
      hold = m_hold; who = m_who; wr = m_wr;
      ad = m_adone; wf = m_wf; bf = m_bf;
      err = m_err; prio = m_prio; q = m_quiet;
      hs = ar_hs | r_last_hs | aw_hs | w_last_hs | b_hs;
      if (hold) begin
        req = who ? d_req : i_req;
        if (!hs && q == TO - 1) begin
          hold = 0;
          err = 1;
        end else begin
          if (wr) begin
            wf = wf | w_last_hs;
            bf = bf | b_hs;
          end
          if (!ad) begin
            if (wr ? aw_hs : ar_hs) ad = 1;
            else if (!req) hold = 0;
          end else if (wr ? (wf && bf) : r_last_hs) begin
            hold = 0;
          end
          q = hs ? 0 : q + 1;
        end
      end else if (i_req || d_req) begin
        who  = (i_req && d_req) ? prio : d_req;
        wr   = who ? d_write : i_write;
        prio = !who;
        hold = 1; ad = 0; wf = 0; bf = 0; q = 0;
      end
      m_hold <= hold; m_who <= who; m_wr <= wr;
      m_adone <= ad; m_wf <= wf; m_bf <= bf;
      m_err <= err; m_prio <= prio; m_quiet <= q;
    end
  end

  always @(negedge clk) begin
    chk("grant_i", grant_i, m_hold && !m_who);
    chk("grant_d", grant_d, m_hold && m_who);
    chk("bus_busy", bus_busy, m_hold);
    chk("timeout_err", timeout_err, m_err);
    if (m_hold) chk("owner", owner, m_who);
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clr();
    i_req = 0; i_write = 0; d_req = 0; d_write = 0;
    ar_hs = 0; r_last_hs = 0; aw_hs = 0;
    w_last_hs = 0; b_hs = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_time_limit got=1 exp=0");
    $fatal(1);
  end

  initial begin
    repeat (3) tick();
    chk("rst_grant_i", grant_i, 0);
    chk("rst_grant_d", grant_d, 0);
    chk("rst_owner", owner, 0);
    chk("rst_busy", bus_busy, 0);
    chk("rst_err", timeout_err, 0);
    rst_n = 1;
    tick();

    // conflict after reset: D first, then I after one idle cycle
    i_req = 1; d_req = 1;
    tick();
    chk("s1_grant_d", grant_d, 1);
    chk("s1_grant_i", grant_i, 0);
    ar_hs = 1;
    tick();
    ar_hs = 0; r_last_hs = 1;
    tick();
    chk("s1_gap_d", grant_d, 0);
    chk("s1_gap_i", grant_i, 0);
    r_last_hs = 0; d_req = 0;
    tick();
    chk("s1_next_i", grant_i, 1);
    ar_hs = 1;
    tick();
    ar_hs = 0; r_last_hs = 1; i_req = 0;
    tick();
    clr();
    tick();

    // D write, W last two cycles ahead of AW
    d_req = 1; d_write = 1;
    tick();
    chk("s2_grant", grant_d, 1);
    w_last_hs = 1;
    tick();
    w_last_hs = 0;
    tick();
    aw_hs = 1;
    tick();
    aw_hs = 0; d_req = 0;
    tick();
    chk("s2_data_hold", grant_d, 1);
    b_hs = 1;
    tick();
    chk("s2_after_b", grant_d, 0);
    clr();
    tick();

    // I read timeline, stray r_last in ADDR ignored
    i_req = 1;
    chk("s3_c0", bus_busy, 0);
    for (int c = 1; c <= 11; c++) begin
      tick();
      chk("s3_busy", bus_busy, int'(c <= 10));
      ar_hs = (c == 3);
      r_last_hs = (c == 10) || (c == 2);
      i_req = (c < 10);
    end
    chk("s3_c11_grant", grant_i, 0);
    clr();
    tick();

    // D abort in ADDR
    d_req = 1; d_write = 1;
    tick();
    tick();
    d_req = 0;
    tick();
    chk("s4_grant", grant_d, 0);
    chk("s4_busy", bus_busy, 0);
    chk("s4_err", timeout_err, 0);
    clr();
    tick();

    // timeout with request held
    i_req = 1;
    tick();
    held = 0;
    for (int n = 0; n < 40; n++) begin
      if (!grant_i) break;
      held++;
      tick();
    end
    chk("s5_held", held, TO);
    chk("s5_err", timeout_err, 1);
    chk("s5_dropped", grant_i, 0);
    tick();
    chk("s5_regrant", grant_i, 1);
    ar_hs = 1;
    tick();
    ar_hs = 0; r_last_hs = 1; i_req = 0;
    tick();
    clr();
    chk("s5_done", grant_i, 0);
    chk("s5_sticky", timeout_err, 1);
    tick();

    // I write, W last and B together in DATA
    i_req = 1; i_write = 1;
    tick();
    aw_hs = 1;
    tick();
    aw_hs = 0; w_last_hs = 1; b_hs = 1;
    chk("s7_hold", grant_i, 1);
    tick();
    chk("s7_release", grant_i, 0);
    clr();
    tick();

    // reset during DATA
    d_req = 1;
    tick();
    ar_hs = 1;
    tick();
    ar_hs = 0;
    chk("s6_in_data", grant_d, 1);
    #2 rst_n = 0;
    #1;
    chk("s6_async_d", grant_d, 0);
    chk("s6_async_busy", bus_busy, 0);
    chk("s6_async_err", timeout_err, 0);
    d_req = 0;
    tick();
    tick();
    rst_n = 1;
    i_req = 1; d_req = 1;
    tick();
    chk("s6_d_wins", grant_d, 1);
    chk("s6_i_loses", grant_i, 0);
    ar_hs = 1;
    tick();
    ar_hs = 0; r_last_hs = 1; d_req = 0;
    tick();
    r_last_hs = 0;
    tick();
    chk("s6_i_next", grant_i, 1);
    ar_hs = 1;
    tick();
    ar_hs = 0; r_last_hs = 1; i_req = 0;
    tick();
    clr();
    tick();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/axi_txn_scheduler.md
AXI_TXN_SCHEDULER -- requirements
Module: axi_txn_scheduler

Interface
REQ-001 The module SHALL have parameter TIMEOUT_CYCLES, default 1024, meaning the maximum number of cycles without a handshake while a grant is held.
REQ-002 The module SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-003 The module SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-004 The module SHALL have port i_req, input, 1, instruction cache requests the shared AXI master.
REQ-005 The module SHALL have port i_write, input, 1, instruction cache request is a write (1) or a read (0).
REQ-006 The module SHALL have port d_req, input, 1, data cache requests the shared AXI master.
REQ-007 The module SHALL have port d_write, input, 1, data cache request is a write (1) or a read (0).
REQ-008 The module SHALL have port ar_hs, input, 1, arvalid&arready seen on the shared master.
REQ-009 The module SHALL have port r_last_hs, input, 1, rvalid&rready&rlast seen.
REQ-010 The module SHALL have port aw_hs, input, 1, awvalid&awready seen.
REQ-011 The module SHALL have port w_last_hs, input, 1, wvalid&wready&wlast seen.
REQ-012 The module SHALL have port b_hs, input, 1, bvalid&bready seen.
REQ-013 The module SHALL have port grant_i, output, 1, instruction cache owns the bus.
REQ-014 The module SHALL have port grant_d, output, 1, data cache owns the bus.
REQ-015 The module SHALL have port owner, output, 1, owner select for the channel mux: 0 = I, 1 = D, valid while a grant is held.
REQ-016 The module SHALL have port bus_busy, output, 1, high in any state other than IDLE.
REQ-017 The module SHALL have port timeout_err, output, 1, sticky timeout flag.

Function
REQ-018 States SHALL be IDLE, ADDR and DATA; grant_i and grant_d SHALL be registered and never both high.
REQ-019 In IDLE with any request asserted, the module SHALL latch the winner and its write bit and enter ADDR; the grant SHALL be high the following cycle (1-cycle latency).
REQ-020 On simultaneous i_req and d_req, the requester not served last SHALL win (round-robin); after reset, D SHALL win the first conflict.
REQ-021 ADDR read: ar_hs SHALL move the FSM to DATA.
REQ-022 ADDR write: aw_hs SHALL move the FSM to DATA.
REQ-023 In a write, w_last_hs and b_hs SHALL be recorded in done flags in both ADDR and DATA, because W may precede AW.
REQ-024 In ADDR, if the owner deasserts its request before its address handshake, the module SHALL return to IDLE with no transaction issued.
REQ-025 In DATA, request deassertion SHALL be ignored.
REQ-026 A read SHALL complete on r_last_hs in DATA; r_last_hs in ADDR SHALL be ignored.
REQ-027 A write SHALL complete once both the W-last flag and the B flag are set; they may be set in the same cycle or in any order, with b_hs required after aw_hs.
REQ-028 On completion, the FSM SHALL go to IDLE and the grant SHALL drop the next cycle.
REQ-029 Each release SHALL leave at least one IDLE cycle with no grant before the next grant.
REQ-030 A timeout counter SHALL run in ADDR and DATA, clear on any handshake input, and clear on entry to IDLE.
REQ-031 When the timeout counter reaches TIMEOUT_CYCLES-1, the module SHALL set timeout_err, force IDLE and drop the grant.
REQ-032 timeout_err SHALL stay set until reset; arbitration SHALL continue after it is set.
REQ-033 The counter width SHALL be $clog2(TIMEOUT_CYCLES) and the counter SHALL never wrap.

Reset
REQ-034 While rst_n=0, the module SHALL hold state=IDLE, grant_i=0, grant_d=0, owner=0, bus_busy=0, timeout_err=0, done flags cleared, timeout counter=0, and last-served pointer=I (so D wins first).
REQ-035 Reset asserted mid-transaction SHALL drop grants immediately (asynchronously), with no completion signalled.

Structure
REQ-036 arb_state_t (IDLE/ADDR/DATA) and arb_owner_t (OWNER_I=0, OWNER_D=1) SHALL be defined in holy_core_pkg.
REQ-037 The timeout counter MAY be a sub-module named txn_watchdog; everything else SHALL stay inline.
REQ-038 The AXI channel mux SHALL stay outside this block and be driven by owner.

Verification
REQ-039 Scenario: i_req=d_req=1 right after reset -> grant_d=1 one cycle later; after D read completes, grant_i=1 after one IDLE cycle.
REQ-040 Scenario: D write with w_last_hs two cycles before aw_hs, then b_hs -> grant_d held until the cycle after b_hs, then released.
REQ-041 Scenario: I read with ar_hs at cycle 3 and r_last_hs at cycle 10 -> bus_busy high cycles 1-10, grant_i low at cycle 11.
REQ-042 Scenario: d_req dropped in ADDR before aw_hs -> IDLE next cycle, grant_d=0, no timeout.
REQ-043 Scenario: TIMEOUT_CYCLES=16, grant held with no handshakes -> timeout_err=1 at the 16th cycle, grant dropped, a later i_req is granted normally.
REQ-044 Scenario: rst_n pulsed low during DATA -> grants 0 immediately, timeout_err=0, next conflict won by D.
